lms_fir_engine: RTL and testbench

- Adaptive LMS FIR filter that sits directly downstream of the sample controller.
- On each fir_go pulse it performs three steps:
  - updates every tap weight using the supplied weight_adjust and the previous input vector;
  - shifts the new sample into the delay line;
  - computes the filter output serially with one shared 16x16 multiplier.
- Returns the 32-bit result with a one-cycle fir_done pulse, which the controller samples as fir_done/fir_out.

---
 rtl/lms_fir_engine.sv | 158 +++++++++++++++
 tb/tb_lms_fir_engine.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/lms_fir_engine.sv
// Adaptive LMS FIR engine. Each fir_go does a weight update, a delay-line shift and a serial
// MAC pass. All three steps share one 16x16 signed multiplier.
module lms_fir_engine #(
  parameter int unsigned TAPS = 16,
  parameter int unsigned FRAC = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fir_go,
  input  logic [15:0] x_in,
  input  logic [15:0] weight_adjust,
  output logic [31:0] fir_out,
  output logic        fir_done,
  output logic        busy
);

  localparam int unsigned KW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int unsigned AW = 32 + $clog2(TAPS);
  localparam logic [KW-1:0] KLast = KW'(TAPS - 1);

  typedef enum logic [2:0] {StIdle, StUpd, StShift, StMac, StDone} state_e;

  state_e                state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic signed [15:0]    x_q [TAPS];
  logic signed [15:0]    x_d [TAPS];
  logic signed [15:0]    w_q [TAPS];
  logic signed [15:0]    w_d [TAPS];
  logic signed [15:0]    xin_q, xin_d;
  logic signed [15:0]    wa_q, wa_d;
  logic [31:0]           fir_out_q, fir_out_d;
  logic                  fir_done_q, fir_done_d;
  logic                  busy_q, busy_d;

  // Shared multiplier: the step term during UPD, the weight during MAC; both use x[k].
  logic signed [15:0] mul_a, mul_b;
  logic signed [31:0] prod;
  assign mul_a = (state_q == StMac) ? w_q[k_q] : wa_q;
  assign mul_b = x_q[k_q];
  assign prod  = mul_a * mul_b;

  logic signed [31:0] upd_sh;
  logic signed [32:0] upd_sum;
  logic signed [15:0] w_new;
  assign upd_sh  = prod >>> FRAC;
  assign upd_sum = {{17{w_q[k_q][15]}}, w_q[k_q]} + {upd_sh[31], upd_sh};

  always_comb begin
    if (upd_sum > 33'sd32767) begin
      w_new = 16'sh7FFF;
    end else if (upd_sum < -33'sd32768) begin
      w_new = 16'sh8000;
    end else begin
      w_new = upd_sum[15:0];
    end
  end

  // Result fits in 32 bits only when every bit above bit 30 matches the sign.
  logic [31:0] acc_sat;
  always_comb begin
    if (acc_q[AW-1:31] == '0 || acc_q[AW-1:31] == '1) begin
      acc_sat = acc_q[31:0];
    end else begin
      acc_sat = acc_q[AW-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    acc_d      = acc_q;
    x_d        = x_q;
    w_d        = w_q;
    xin_d      = xin_q;
    wa_d       = wa_q;
    fir_out_d  = fir_out_q;
    fir_done_d = 1'b0;
    busy_d     = busy_q;
    unique case (state_q)
      StIdle: begin
        if (fir_go) begin
          xin_d   = x_in;
          wa_d    = weight_adjust;
          k_d     = '0;
          busy_d  = 1'b1;
          state_d = StUpd;
        end
      end
      StUpd: begin
        w_d[k_q] = w_new;
        if (k_q == KLast) begin
          k_d     = '0;
          state_d = StShift;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      StShift: begin
        for (int j = 1; j < int'(TAPS); j++) begin
          x_d[j] = x_q[j-1];
        end
        x_d[0]  = xin_q;
        acc_d   = '0;
        k_d     = '0;
        state_d = StMac;
      end
      StMac: begin
        acc_d = acc_q + {{(AW-32){prod[31]}}, prod};
        if (k_q == KLast) begin
          state_d = StDone;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      StDone: begin
        fir_out_d  = acc_sat;
        fir_done_d = 1'b1;
        busy_d     = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      k_q        <= '0;
      acc_q      <= '0;
      xin_q      <= '0;
      wa_q       <= '0;
      fir_out_q  <= '0;
      fir_done_q <= 1'b0;
      busy_q     <= 1'b0;
      for (int j = 0; j < int'(TAPS); j++) begin
        x_q[j] <= '0;
        w_q[j] <= '0;
      end
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      xin_q      <= xin_d;
      wa_q       <= wa_d;
      fir_out_q  <= fir_out_d;
      fir_done_q <= fir_done_d;
      busy_q     <= busy_d;
      x_q        <= x_d;
      w_q        <= w_d;
    end
  end

  assign fir_out  = fir_out_q;
  assign fir_done = fir_done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_lms_fir_engine.sv
// Directed bench for lms_fir_engine: latency, training, weight and output saturation,
// stray-go protocol and mid-operation reset, all against hand-computed results.
module tb_lms_fir_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        fir_go;
  logic [15:0] x_in;
  logic [15:0] weight_adjust;
  logic [31:0] fir_out;
  logic        fir_done;
  logic        busy;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int exp_done = 0;

  lms_fir_engine #(.TAPS(16), .FRAC(15)) dut (
    .clk           (clk),
    .rst           (rst),
    .fir_go        (fir_go),
    .x_in          (x_in),
    .weight_adjust (weight_adjust),
    .fir_out       (fir_out),
    .fir_done      (fir_done),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (fir_done) done_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    rst    = 1'b1;
    fir_go = 1'b0;
    tick();
    rst    = 1'b0;
    check({tag, " out"}, fir_out, 32'h0);
    check({tag, " done"}, {31'b0, fir_done}, 32'h0);
    check({tag, " busy"}, {31'b0, busy}, 32'h0);
  endtask

  // Returns on the sample where fir_done is high, so a following call is a back-to-back go.
  task automatic run(input logic [15:0] x, input logic [15:0] wa, input logic [31:0] exp,
                     input bit chk, input bit stray, input string tag);
    int lat;
    int bcnt;
    fir_go        = 1'b1;
    x_in          = x;
    weight_adjust = wa;
    tick();
    fir_go        = 1'b0;
    x_in          = 16'h1234;
    weight_adjust = 16'h5A5A;
    lat  = 0;
    bcnt = 0;
    while (!fir_done && lat < 100) begin
      if (busy) bcnt++;
      if (stray && (lat == 4 || lat == 19 || lat == 33)) begin
        fir_go        = 1'b1;
        x_in          = 16'h7FFF;
        weight_adjust = 16'h7FFF;
      end else begin
        fir_go = 1'b0;
      end
      tick();
      lat++;
    end
    fir_go = 1'b0;
    exp_done++;
    check({tag, " latency"}, lat, 32'd34);
    check({tag, " busy cycles"}, bcnt, 32'd34);
    check({tag, " busy at done"}, {31'b0, busy}, 32'h0);
    if (chk) check({tag, " out"}, fir_out, exp);
  endtask

  initial begin
    rst           = 1'b1;
    fir_go        = 1'b0;
    x_in          = '0;
    weight_adjust = '0;
    tick();
    do_reset("reset");

    // First op and single-pulse done
    run(16'h4000, 16'h0000, 32'h0, 1'b1, 1'b0, "go1");
    tick();
    check("go1 done pulse", {31'b0, fir_done}, 32'h0);
    check("go1 done count", done_cnt, exp_done);

    // Training
    run(16'h0000, 16'h2000, 32'h0, 1'b1, 1'b0, "train2");
    run(16'h4000, 16'h0000, 32'h0400_0000, 1'b1, 1'b0, "train3");

    // Stray go in UPD, MAC and DONE must be ignored
    run(16'h0000, 16'h2000, 32'h0, 1'b1, 1'b1, "stray");
    repeat (40) tick();
    check("stray busy idle", {31'b0, busy}, 32'h0);
    check("stray done count", done_cnt, exp_done);
    check("stray out held", fir_out, 32'h0);
    run(16'h4000, 16'h0000, 32'h0C00_0000, 1'b1, 1'b0, "after stray");

    // Weight saturation, positive
    do_reset("reset pos");
    run(16'h7FFF, 16'h0000, 32'h0, 1'b1, 1'b0, "pos fill");
    run(16'h7FFF, 16'h7FFF, 32'h3FFE_8002, 1'b1, 1'b0, "pos step1");
    run(16'h7FFF, 16'h7FFF, 32'h7FFD_8003, 1'b1, 1'b0, "pos clamp");

    // Weight saturation, negative
    do_reset("reset neg");
    run(16'h7FFF, 16'h0000, 32'h0, 1'b1, 1'b0, "neg fill");
    run(16'h7FFF, 16'h8000, 32'hC000_FFFF, 1'b1, 1'b0, "neg step1");
    run(16'h7FFF, 16'h8000, 32'h8001_7FFF, 1'b1, 1'b0, "neg clamp");

    // Output saturation with all weights at 0x7FFF
    do_reset("reset osat");
    for (int i = 0; i < 16; i++) run(16'h7FFF, 16'h0000, 32'h0, 1'b0, 1'b0, "osat prefill");
    run(16'h7FFF, 16'h7FFF, 32'h0, 1'b0, 1'b0, "osat train1");
    run(16'h7FFF, 16'h7FFF, 32'h0, 1'b0, 1'b0, "osat train2");
    for (int i = 0; i < 16; i++) begin
      run(16'h8000, 16'h0000, 32'h8000_0000, (i == 15), 1'b0, "osat neg");
    end
    for (int i = 0; i < 16; i++) begin
      run(16'h7FFF, 16'h0000, 32'h7FFF_FFFF, (i == 15), 1'b0, "osat pos");
    end
    tick();
    check("osat done count", done_cnt, exp_done);

    // Reset in MAC at k=7 aborts the op and clears state
    do_reset("reset mac");
    run(16'h4000, 16'h0000, 32'h0, 1'b1, 1'b0, "pre1");
    run(16'h0000, 16'h2000, 32'h0, 1'b1, 1'b0, "pre2");
    run(16'h4000, 16'h0000, 32'h0400_0000, 1'b1, 1'b0, "pre3");
    fir_go        = 1'b1;
    x_in          = 16'h4000;
    weight_adjust = 16'h0000;
    tick();
    fir_go = 1'b0;
    repeat (24) tick();
    check("mid busy", {31'b0, busy}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid rst out", fir_out, 32'h0);
    check("mid rst busy", {31'b0, busy}, 32'h0);
    check("mid rst done", {31'b0, fir_done}, 32'h0);
    repeat (40) tick();
    check("mid rst no done", done_cnt, exp_done);
    run(16'h4000, 16'h0000, 32'h0, 1'b1, 1'b0, "post weights");
    run(16'h0000, 16'h2000, 32'h0, 1'b1, 1'b0, "post delay");
    run(16'h4000, 16'h0000, 32'h0400_0000, 1'b1, 1'b0, "post retrain");
    tick();
    check("final done count", done_cnt, exp_done);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
